// File: rtl/mem_resp_sram.sv
// Word-addressed SRAM responder with valid/ready request and response channels.
// Define MEM_RESP_RAND_DELAY_EN to randomise per-request latency in 1..LATENCY.
module mem_resp_sram #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [31:0]       addr_off;
  logic [IDX_W-1:0]  req_idx;
  logic              in_range;
  logic [3:0]        lat_eff;

  logic              enter_resp;
  logic              mem_we;
  logic              acc_wen;
  logic              acc_err;
  logic [IDX_W-1:0]  acc_idx;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_wmask;

  assign addr_off = req_addr - ADDR_BASE;
  assign req_idx  = IDX_W'(addr_off >> 2);
  assign in_range = ({1'b0, req_addr} >= {1'b0, ADDR_BASE}) && ({1'b0, req_addr} < ADDR_LIMIT);

`ifdef MEM_RESP_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == IDLE && req_valid) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign lat_eff = 4'd1 + (lfsr_q[3:0] % 4'(LATENCY));
`else
  assign lat_eff = 4'(LATENCY);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wen_d      = wen_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    enter_resp = 1'b0;
    acc_wen    = wen_q;
    acc_err    = err_q;
    acc_idx    = idx_q;
    acc_wdata  = wdata_q;
    acc_wmask  = wmask_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d     = req_wen;
          idx_d     = req_idx;
          wdata_d   = req_wdata;
          wmask_d   = req_wmask;
          err_d     = !in_range;
          // Single-cycle latency enters RESP straight from IDLE, so access uses the live request.
          acc_wen   = req_wen;
          acc_err   = !in_range;
          acc_idx   = req_idx;
          acc_wdata = req_wdata;
          acc_wmask = req_wmask;
          if (lat_eff == 4'd1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = lat_eff - 4'd1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      rdata_d = (!acc_wen && !acc_err) ? mem[acc_idx] : '0;
    end
    mem_we = enter_resp && acc_wen && !acc_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_wmask[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_resp_sram.sv
// Directed self-checking bench for mem_resp_sram with default parameters (LATENCY=2, 1024 words).
module tb_mem_resp_sram;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  mem_resp_sram #(
    .ADDR_BASE   (32'h8000_0000),
    .DEPTH_WORDS (1024),
    .LATENCY     (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request/response; response is held off for 'hold' cycles before resp_ready.
  task automatic xact(input string tag, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wmask, input int hold,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    chk({tag, ".req_ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    tick();
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 20) begin
      chk({tag, ".req_ready_busy"}, {31'd0, req_ready}, 32'd0);
      tick();
      n++;
    end
    chk({tag, ".latency"}, n, 32'd2);
    chk({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, ".rdata"}, resp_rdata, exp_rdata);
    chk({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".hold_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, ".hold_rdata"}, resp_rdata, exp_rdata);
      chk({tag, ".hold_err"}, {31'd0, resp_err}, {31'd0, exp_err});
      chk({tag, ".hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, ".post_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, ".post_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    resp_ready = 1'b0;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset.req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset.resp_err", {31'd0, resp_err}, 32'd0);
    chk("reset.resp_rdata", resp_rdata, 32'd0);

    xact("wr_full",  1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
    xact("rd_full",  1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0);
    xact("wr_mask",  1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, 32'h0, 1'b0);
    xact("rd_mask",  1'b0, 32'h8000_0012, 32'h0,         4'h0, 0, 32'hDE22_BE44, 1'b0);
    xact("rd_hold",  1'b0, 32'h8000_0010, 32'h0,         4'h0, 5, 32'hDE22_BE44, 1'b0);
    xact("wr_zmask", 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 32'h0, 1'b0);
    xact("rd_zmask", 1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'hDE22_BE44, 1'b0);

    xact("wr_w0",    1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b0);
    xact("wr_last",  1'b1, 32'h8000_0FFE, 32'h0BAD_C0DE, 4'hF, 0, 32'h0, 1'b0);
    xact("rd_last",  1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 0, 32'h0BAD_C0DE, 1'b0);
    xact("rd_below", 1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 0, 32'h0, 1'b1);
    xact("wr_above", 1'b1, 32'h8000_1000, 32'h5555_AAAA, 4'hF, 0, 32'h0, 1'b1);
    xact("rd_w0",    1'b0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'hCAFE_F00D, 1'b0);

    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0000;
    req_wdata = 32'h1234_5678;
    req_wmask = 4'hF;
    tick();
    req_valid = 1'b0;
    chk("rst_wait.req_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_wait.async_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_wait.valid_in_reset", {31'd0, resp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_wait.valid_after", {31'd0, resp_valid}, 32'd0);
    end
    xact("rd_w0_after_rst", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
